// File: rtl/crop_pkg.sv
// crop_pkg: shared pixel type, FSM state encoding and default window
// geometry for the crop stream source.
package crop_pkg;

    localparam int DEF_FP_TOTAL = 16;
    localparam int DEF_IN_ROWS  = 100;
    localparam int DEF_IN_COLS  = 160;
    localparam int DEF_OUT_ROWS = 48;
    localparam int DEF_OUT_COLS = 48;
    localparam int DEF_Y_1      = 10;
    localparam int DEF_X_1      = 10;

    typedef logic [DEF_FP_TOTAL-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crop_axis_out_reg.sv
// crop_axis_out_reg: single-entry AXI-stream register carrying data+last.
// A load always wins over a drain, so transfer+load keeps valid high.
module crop_axis_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/crop_stream_source.sv
// crop_stream_source: consumes a raster image and forwards only the
// OUT_ROWS x OUT_COLS window at (Y_1, X_1) under ap_start/ap_done control.
module crop_stream_source
    import crop_pkg::*;
#(
    parameter int FP_TOTAL = DEF_FP_TOTAL,
    parameter int IN_ROWS  = DEF_IN_ROWS,
    parameter int IN_COLS  = DEF_IN_COLS,
    parameter int OUT_ROWS = DEF_OUT_ROWS,
    parameter int OUT_COLS = DEF_OUT_COLS,
    parameter int Y_1      = DEF_Y_1,
    parameter int X_1      = DEF_X_1
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    input  logic [FP_TOTAL-1:0] img_in_TDATA,
    input  logic                img_in_TVALID,
    output logic                img_in_TREADY,
    output logic [FP_TOTAL-1:0] conv2d_input_V_data_0_V_TDATA,
    output logic                conv2d_input_V_data_0_V_TVALID,
    input  logic                conv2d_input_V_data_0_V_TREADY,
    output logic                conv2d_input_V_data_0_V_TLAST
);

    localparam int RW = cnt_w(IN_ROWS);
    localparam int CW = cnt_w(IN_COLS);

    if (Y_1 + OUT_ROWS > IN_ROWS) begin : g_bad_rows
        $error("crop window exceeds image rows");
    end
    if (X_1 + OUT_COLS > IN_COLS) begin : g_bad_cols
        $error("crop window exceeds image columns");
    end
    if (OUT_ROWS == 0 || OUT_COLS == 0) begin : g_bad_size
        $error("crop window is empty");
    end

    localparam logic [RW:0]   ROW_LO   = (RW+1)'(Y_1);
    localparam logic [RW:0]   ROW_N    = (RW+1)'(OUT_ROWS);
    localparam logic [CW:0]   COL_LO   = (CW+1)'(X_1);
    localparam logic [CW:0]   COL_N    = (CW+1)'(OUT_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(Y_1 + OUT_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(X_1 + OUT_COLS - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_END  = CW'(IN_COLS - 1);

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_done;

    logic          w_out_valid;
    logic          w_out_ready;
    logic          w_in_fire;
    logic          w_load;
    logic [RW:0]   w_row_off;
    logic [CW:0]   w_col_off;
    logic          w_in_win;
    logic          w_win_last;
    logic          w_col_end;
    logic          w_row_end;

    assign w_out_ready = conv2d_input_V_data_0_V_TREADY;

    // Offsets wrap to large values below the window, so one compare per axis.
    assign w_row_off  = {1'b0, r_row} - ROW_LO;
    assign w_col_off  = {1'b0, r_col} - COL_LO;
    assign w_in_win   = (w_row_off < ROW_N) && (w_col_off < COL_N);
    assign w_win_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_col_end  = (r_col == COL_END);
    assign w_row_end  = (r_row == ROW_END);

    assign img_in_TREADY = (r_state == RUN) && (!w_out_valid || w_out_ready);
    assign w_in_fire     = img_in_TVALID && img_in_TREADY;
    assign w_load        = w_in_fire && w_in_win;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_state <= RUN;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                RUN: begin
                    if (w_in_fire) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            if (w_row_end) begin
                                r_row   <= '0;
                                r_state <= DRAIN;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Done lands the cycle after the register empties.
                    if (!w_out_valid || w_out_ready) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ap_done = r_done;
    assign ap_idle = (r_state == IDLE);

    crop_axis_out_reg #(
        .W(FP_TOTAL)
    ) u_out_reg (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_load  (w_load),
        .i_data  (img_in_TDATA),
        .i_last  (w_win_last),
        .i_ready (w_out_ready),
        .o_valid (w_out_valid),
        .o_data  (conv2d_input_V_data_0_V_TDATA),
        .o_last  (conv2d_input_V_data_0_V_TLAST)
    );

    assign conv2d_input_V_data_0_V_TVALID = w_out_valid;

endmodule

// File: tb/tb_crop_stream_source.sv
// tb_crop_stream_source: scoreboard bench for the crop engine, default
// window plus a bottom-right corner window instance.
module tb_crop_stream_source;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        string nm;
        bit    rnd;
        int    stall;
        bit    pulse;
        int    abort_at;
        int    exp_first;
        int    exp_last;
        int    exp_beats;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 1'b0;
    logic        a_ivalid = 1'b0;
    logic        a_oready = 1'b1;
    logic [15:0] a_idata = '0;
    logic        a_done, a_idle, a_iready, a_ovalid, a_olast;
    logic [15:0] a_odata;

    logic        b_start = 1'b0;
    logic        b_ivalid = 1'b0;
    logic        b_oready = 1'b1;
    logic [15:0] b_idata = '0;
    logic        b_done, b_idle, b_iready, b_ovalid, b_olast;
    logic [15:0] b_odata;

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    crop_stream_source u_dut_a (
        .ap_clk                         (clk),
        .ap_rst_n                       (rst_n),
        .ap_start                       (a_start),
        .ap_done                        (a_done),
        .ap_idle                        (a_idle),
        .img_in_TDATA                   (a_idata),
        .img_in_TVALID                  (a_ivalid),
        .img_in_TREADY                  (a_iready),
        .conv2d_input_V_data_0_V_TDATA  (a_odata),
        .conv2d_input_V_data_0_V_TVALID (a_ovalid),
        .conv2d_input_V_data_0_V_TREADY (a_oready),
        .conv2d_input_V_data_0_V_TLAST  (a_olast)
    );

    crop_stream_source #(
        .Y_1(52),
        .X_1(112)
    ) u_dut_b (
        .ap_clk                         (clk),
        .ap_rst_n                       (rst_n),
        .ap_start                       (b_start),
        .ap_done                        (b_done),
        .ap_idle                        (b_idle),
        .img_in_TDATA                   (b_idata),
        .img_in_TVALID                  (b_ivalid),
        .img_in_TREADY                  (b_iready),
        .conv2d_input_V_data_0_V_TDATA  (b_odata),
        .conv2d_input_V_data_0_V_TVALID (b_ovalid),
        .conv2d_input_V_data_0_V_TREADY (b_oready),
        .conv2d_input_V_data_0_V_TLAST  (b_olast)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit in_win(input int r, input int c,
                                  input int y1, input int x1);
        return (r >= y1) && (r < y1 + 48) && (c >= x1) && (c < x1 + 48);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_idle"},   32'(a_idle),   1);
        chk({tag, "_done"},   32'(a_done),   0);
        chk({tag, "_iready"}, 32'(a_iready), 0);
        chk({tag, "_ovalid"}, 32'(a_ovalid), 0);
        chk({tag, "_odata"},  32'(a_odata),  0);
        chk({tag, "_olast"},  32'(a_olast),  0);
    endtask

    task automatic run_frame(input frame_vec_t v);
        int r = 0, c = 0, raw = 0, outs = 0, dones = 0, post = 0;
        int cyc = 0, st_left = v.stall, last_d = -1;
        bit fin = 0, stalling;
        exp_t e;
        qa.delete();
        while (!fin && cyc < 80000) begin
            @(negedge clk);
            if (v.abort_at > 0 && raw == v.abort_at) begin
                a_ivalid = 1'b0;
                #1 rst_n = 1'b0;
                #1 check_reset({v.nm, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                qa.delete();
                return;
            end
            a_start  = (cyc == 0) || (v.pulse && cyc >= 3000 && cyc < 3003);
            a_ivalid = (raw < 16000) && (v.rnd ? 1'($urandom_range(1, 0)) : 1'b1);
            a_idata  = 16'(r * 160 + c);
            stalling = (st_left > 0) && a_ovalid;
            if (stalling) begin
                a_oready = 1'b0;
                st_left--;
            end else begin
                a_oready = v.rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            #1;
            if (stalling) begin
                chk({v.nm, "_hold_data"},   32'(a_odata),  v.exp_first);
                chk({v.nm, "_hold_valid"},  32'(a_ovalid), 1);
                chk({v.nm, "_hold_iready"}, 32'(a_iready), 0);
            end
            if (a_ovalid && a_oready) begin
                outs++;
                if (qa.size() == 0) begin
                    chk({v.nm, "_unexpected_out"}, 32'(a_odata), 32'hFFFF_FFFF);
                end else begin
                    e = qa.pop_front();
                    chk({v.nm, "_data"}, 32'(a_odata), 32'(e.d));
                    chk({v.nm, "_last"}, 32'(a_olast), 32'(e.l));
                end
                if (outs == 1) chk({v.nm, "_first"}, 32'(a_odata), v.exp_first);
                if (a_olast) last_d = int'(a_odata);
            end
            if (a_ivalid && a_iready) begin
                if (in_win(r, c, 10, 10)) begin
                    e.d = 16'(r * 160 + c);
                    e.l = (r == 57) && (c == 57);
                    qa.push_back(e);
                end
                raw++;
                if (c == 159) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
            end
            if (a_done) begin
                dones++;
                chk({v.nm, "_idle_with_done"}, 32'(a_idle), 1);
            end
            if (dones > 0) begin
                post++;
                if (post > 3) fin = 1;
            end
            cyc++;
        end
        a_ivalid = 1'b0;
        a_oready = 1'b1;
        a_start  = 1'b0;
        chk({v.nm, "_finished"}, 32'(fin), 1);
        chk({v.nm, "_raw_beats"}, raw, 16000);
        chk({v.nm, "_out_beats"}, outs, v.exp_beats);
        chk({v.nm, "_last_data"}, last_d, v.exp_last);
        chk({v.nm, "_done_pulses"}, dones, 1);
        chk({v.nm, "_queue_empty"}, qa.size(), 0);
    endtask

    task automatic run_corner();
        int r = 0, c = 0, raw = 0, outs = 0, dones = 0, post = 0;
        int cyc = 0, last_d = -1;
        bit fin = 0, prev_last = 0;
        exp_t e;
        qb.delete();
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            b_start  = (cyc == 0);
            b_ivalid = (raw < 16000);
            b_idata  = 16'(r * 160 + c);
            b_oready = 1'b1;
            #1;
            if (prev_last) chk("corner_done_after_last", 32'(b_done), 1);
            prev_last = 0;
            if (b_ovalid && b_oready) begin
                outs++;
                if (qb.size() == 0) begin
                    chk("corner_unexpected_out", 32'(b_odata), 32'hFFFF_FFFF);
                end else begin
                    e = qb.pop_front();
                    chk("corner_data", 32'(b_odata), 32'(e.d));
                    chk("corner_last", 32'(b_olast), 32'(e.l));
                end
                if (outs == 1) chk("corner_first", 32'(b_odata), 8432);
                if (b_olast) begin
                    last_d = int'(b_odata);
                    prev_last = 1;
                end
            end
            if (b_ivalid && b_iready) begin
                if (in_win(r, c, 52, 112)) begin
                    e.d = 16'(r * 160 + c);
                    e.l = (r == 99) && (c == 159);
                    qb.push_back(e);
                end
                raw++;
                if (c == 159) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
            end
            if (b_done) dones++;
            if (dones > 0) begin
                post++;
                if (post > 3) fin = 1;
            end
            cyc++;
        end
        b_ivalid = 1'b0;
        b_start  = 1'b0;
        chk("corner_finished", 32'(fin), 1);
        chk("corner_out_beats", outs, 2304);
        chk("corner_last_data", last_d, 15999);
        chk("corner_done_pulses", dones, 1);
    endtask

    initial begin
        frame_vec_t vecs[4];
        vecs[0] = '{"plain",   0, 0,   1, 0,    1610, 9177, 2304};
        vecs[1] = '{"random",  1, 0,   0, 0,    1610, 9177, 2304};
        vecs[2] = '{"abort",   0, 0,   0, 5000, 1610, 9177, 2304};
        vecs[3] = '{"stall",   0, 100, 0, 0,    1610, 9177, 2304};
        #1;
        check_reset("reset");
        chk("reset_b_idle", 32'(b_idle), 1);
        chk("reset_b_ovalid", 32'(b_ovalid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                fork
                    run_frame(vecs[i]);
                    run_corner();
                join
            end else begin
                run_frame(vecs[i]);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
